// File: rtl/dsm_pkg.sv
// Shared widths, range limits and sequencer state encoding for the MASH 1-1-1 DSM
// sequencer and its ramp generator.
package dsm_pkg;

  localparam int INT_W      = 8;
  localparam int FRAC_W     = 24;
  localparam int DSM_W      = 5;
  localparam int CUR_W      = INT_W + FRAC_W;
  localparam int RAMP_SHIFT = 4;
  localparam int SETTLE_CYC = 3;
  localparam int START_CYC  = 2;
  localparam int INT_MIN    = 4;
  localparam int INT_MAX    = 2**INT_W - 5;

  typedef enum logic [2:0] {OFF, START, SETTLE, RUN, RAMP} state_t;

  function automatic logic int_legal(input logic [INT_W-1:0] v);
    return (int'(v) >= INT_MIN) && (int'(v) <= INT_MAX);
  endfunction

endpackage

// File: rtl/dsm_seq_ctrl_if.sv
// Divide-ratio request channel: valid/ready handshake plus the range-error pulse.
interface dsm_seq_ctrl_if;
  import dsm_pkg::*;

  logic              cfg_valid;
  logic              cfg_ready;
  logic [INT_W-1:0]  cfg_int;
  logic [FRAC_W-1:0] cfg_frac;
  logic              cfg_ramp;
  logic              cfg_err;

  modport master (output cfg_valid, cfg_int, cfg_frac, cfg_ramp,
                  input  cfg_ready, cfg_err);

  modport slave  (input  cfg_valid, cfg_int, cfg_frac, cfg_ramp,
                  output cfg_ready, cfg_err);

endinterface

// File: rtl/dsm_ramp_gen.sv
// Holds the {int, frac} frequency word; jumps to a target or walks to it in
// 2^RAMP_SHIFT equal steps, landing exactly on the target at the last step.
module dsm_ramp_gen
  import dsm_pkg::*;
(
  input  logic             Clk,
  input  logic             reset,
  input  logic             load,
  input  logic             start,
  input  logic             step_en,
  input  logic [CUR_W-1:0] target,
  output logic [CUR_W-1:0] cur,
  output logic             done
);

  logic signed [CUR_W:0]  diff;
  logic [CUR_W-1:0]       step;
  logic [CUR_W-1:0]       tgt;
  logic [RAMP_SHIFT-1:0]  cnt;

  assign diff = $signed({1'b0, target}) - $signed({1'b0, cur});
  assign done = (cnt == '1);

  // The shifted difference carries redundant sign bits, so CUR_W bits hold the
  // step losslessly and modular addition reproduces the signed walk.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      cur  <= '0;
      step <= '0;
      tgt  <= '0;
      cnt  <= '0;
    end else if (load) begin
      cur <= target;
    end else if (start) begin
      step <= CUR_W'(diff >>> RAMP_SHIFT);
      tgt  <= target;
      cnt  <= '0;
    end else if (step_en) begin
      if (done) begin
        cur <= tgt;
      end else begin
        cur <= cur + step;
        cnt <= cnt + RAMP_SHIFT'(1);
      end
    end
  end

endmodule

// File: rtl/dsm_seq_ctrl.sv
// Sequencer for the MASH 1-1-1 DSM: accepts divide-ratio requests, runs the DSM
// reset/settle sequence, ramps or jumps the DSM input and forms the divider modulus.
module dsm_seq_ctrl
  import dsm_pkg::*;
(
  input  logic               Clk,
  input  logic               reset,
  input  logic               en,
  dsm_seq_ctrl_if.slave      cfg,
  output logic               dsm_rst_n,
  output logic [FRAC_W-1:0]  dsm_in,
  input  logic [DSM_W-1:0]   dsm_out,
  output logic [INT_W:0]     div_ratio,
  output logic               div_valid,
  output logic               busy
);

  localparam int CNT_W = 2;

  state_t            state, next_state;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic              alive;
  logic              accept, legal;
  logic              load, start, step_en, ramp_done;
  logic [CUR_W-1:0]  cur;
  logic [CUR_W-1:0]  target;
  logic [INT_W:0]    ratio_sum;

  assign target    = {cfg.cfg_int, cfg.cfg_frac};
  assign legal     = int_legal(cfg.cfg_int);
  assign accept    = cfg.cfg_valid && cfg.cfg_ready;
  assign step_en   = en && (state == RAMP);
  assign dsm_in    = cur[FRAC_W-1:0];
  assign busy      = (state == START) || (state == SETTLE) || (state == RAMP);
  assign ratio_sum = {1'b0, cur[CUR_W-1 -: INT_W]}
                   + {{(INT_W+1-DSM_W){dsm_out[DSM_W-1]}}, dsm_out};

  // alive holds cfg_ready low until the first edge after reset release.
  assign cfg.cfg_ready = alive && en && ((state == OFF) || (state == RUN));

  dsm_ramp_gen u_ramp (
    .Clk     (Clk),
    .reset   (reset),
    .load    (load),
    .start   (start),
    .step_en (step_en),
    .target  (target),
    .cur     (cur),
    .done    (ramp_done)
  );

  always_comb begin
    next_state = state;
    cnt_next   = '0;
    load       = 1'b0;
    start      = 1'b0;
    if (!en) begin
      next_state = OFF;
    end else begin
      case (state)
        OFF: begin
          if (accept && legal) begin
            load       = 1'b1;
            next_state = START;
          end
        end
        START: begin
          if (cnt == CNT_W'(START_CYC - 1)) next_state = SETTLE;
          else                              cnt_next   = cnt + CNT_W'(1);
        end
        SETTLE: begin
          if (cnt == CNT_W'(SETTLE_CYC - 1)) next_state = RUN;
          else                               cnt_next   = cnt + CNT_W'(1);
        end
        RUN: begin
          if (accept && legal) begin
            if (cfg.cfg_ramp) begin
              start      = 1'b1;
              next_state = RAMP;
            end else begin
              load = 1'b1;
            end
          end
        end
        RAMP: begin
          if (ramp_done) next_state = RUN;
        end
        default: next_state = OFF;
      endcase
    end
  end

  // Outputs are registered from next_state so an enable drop resets the DSM
  // and invalidates the modulus on the very edge that enters OFF.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state       <= OFF;
      cnt         <= '0;
      alive       <= 1'b0;
      dsm_rst_n   <= 1'b0;
      div_valid   <= 1'b0;
      div_ratio   <= '0;
      cfg.cfg_err <= 1'b0;
    end else begin
      state       <= next_state;
      cnt         <= cnt_next;
      alive       <= 1'b1;
      dsm_rst_n   <= (next_state == SETTLE) || (next_state == RUN) || (next_state == RAMP);
      div_valid   <= (next_state == RUN) || (next_state == RAMP);
      if ((next_state == RUN) || (next_state == RAMP)) div_ratio <= ratio_sum;
      cfg.cfg_err <= accept && !legal;
    end
  end

endmodule
